// File: rtl/probe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | probe_pkg: shared constants and helpers for the probe scheduler          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package probe_pkg;

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_send = 1'b1;

    localparam int c_ts_w = 32;

    // Probe index width; a single-bit index is kept even for one or two probes.
    function automatic int idw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/probe_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | probe_rr_arb: combinational round-robin picker, search starts at ptr+1   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module probe_rr_arb
    import probe_pkg::*;
#(
    parameter  int NPROBE = 4,
    localparam int IDW    = idw_f(NPROBE)
) (
    input  logic [NPROBE-1:0] req,
    input  logic [IDW-1:0]    ptr,
    output logic              gnt_any,
    output logic [IDW-1:0]    gnt_idx
);

    localparam logic [IDW-1:0] c_last = IDW'(NPROBE - 1);

    logic [IDW-1:0] w_idx;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        w_idx   = ptr;
        for (int k = 0; k < NPROBE; k++) begin
            w_idx = (w_idx == c_last) ? '0 : w_idx + 1'b1;
            if (!gnt_any && req[w_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/probe_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | probe_scheduler: shares one registered debug channel among NPROBE probes |
// | Optional macro PROBE_TS_EN adds a 32-bit capture timestamp (OUT_TS).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module probe_scheduler
    import probe_pkg::*;
#(
    parameter  int NPROBE = 4,
    parameter  int size   = 32,
    localparam int IDW    = idw_f(NPROBE)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NPROBE*size-1:0] IN,
    input  logic                   FORCE,
    output logic [size-1:0]        OUT,
    output logic [IDW-1:0]         OUT_ID,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY
`ifdef PROBE_TS_EN
    ,
    output logic [c_ts_w-1:0]      OUT_TS
`endif
);

    logic [0:0]        r_state;
    logic [IDW-1:0]    r_ptr;
    logic [size-1:0]   r_last [NPROBE];
    logic [NPROBE-1:0] r_fpend;
    logic [size-1:0]   r_out;
    logic [IDW-1:0]    r_out_id;

    logic [NPROBE-1:0] w_req;
    logic              w_gnt_any;
    logic [IDW-1:0]    w_gnt_idx;
    logic [size-1:0]   w_gnt_val;
    logic              w_grant;

    for (genvar i = 0; i < NPROBE; i++) begin : g_req
        assign w_req[i] = (IN[i*size +: size] != r_last[i]) | r_fpend[i];
    end

    probe_rr_arb #(
        .NPROBE (NPROBE)
    ) u_arb (
        .req     (w_req),
        .ptr     (r_ptr),
        .gnt_any (w_gnt_any),
        .gnt_idx (w_gnt_idx)
    );

    assign w_gnt_val = IN[w_gnt_idx*size +: size];
    // A held snapshot blocks new grants until the sink accepts it.
    assign w_grant   = w_gnt_any & ((r_state == c_idle) | OUT_READY);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= c_idle;
            r_ptr    <= IDW'(NPROBE - 1);
            r_out    <= '0;
            r_out_id <= '0;
        end else begin
            if ((r_state == c_idle) || OUT_READY) begin
                r_state <= w_gnt_any ? c_send : c_idle;
            end
            if (w_grant) begin
                r_ptr    <= w_gnt_idx;
                r_out    <= w_gnt_val;
                r_out_id <= w_gnt_idx;
            end
        end
    end

    for (genvar i = 0; i < NPROBE; i++) begin : g_last
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_last[i] <= '0;
            end else if (w_grant && (w_gnt_idx == IDW'(i))) begin
                r_last[i] <= IN[i*size +: size];
            end
        end
    end

    // FORCE wins over the grant clear, so a forced winner is sent again.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fpend <= '0;
        end else if (FORCE) begin
            r_fpend <= '1;
        end else if (w_grant) begin
            r_fpend[w_gnt_idx] <= 1'b0;
        end
    end

`ifdef PROBE_TS_EN
    logic [c_ts_w-1:0] r_cnt;
    logic [c_ts_w-1:0] r_ts;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
            r_ts  <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_grant) begin
                r_ts <= r_cnt;
            end
        end
    end

    assign OUT_TS = r_ts;
`endif

    assign OUT       = r_out;
    assign OUT_ID    = r_out_id;
    assign OUT_VALID = (r_state == c_send);

endmodule
`default_nettype wire

// File: tb/tb_probe_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_probe_scheduler: directed self-checking bench for probe_scheduler     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_probe_scheduler;

    localparam int c_np = 4;
    localparam int c_sz = 32;

    logic                 clk;
    logic                 rst;
    logic [c_np*c_sz-1:0] probes;
    logic                 frc;
    logic [c_sz-1:0]      out;
    logic [1:0]           out_id;
    logic                 out_valid;
    logic                 out_ready;
`ifdef PROBE_TS_EN
    logic [31:0]          out_ts;
`endif

    logic [c_sz-1:0] pv [c_np];
    int n_checks;
    int n_fail;

    assign probes = {pv[3], pv[2], pv[1], pv[0]};

    probe_scheduler #(
        .NPROBE (c_np),
        .size   (c_sz)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .IN        (probes),
        .FORCE     (frc),
        .OUT       (out),
        .OUT_ID    (out_id),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready)
`ifdef PROBE_TS_EN
        ,
        .OUT_TS    (out_ts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input string tag, input logic [1:0] id, input logic [31:0] val);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_id"}, 64'(out_id), 64'(id));
        check({tag, "_out"}, 64'(out), 64'(val));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        frc       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < c_np; i++) pv[i] = '0;

        // Reset state, then idle with all probes at zero.
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_out", 64'(out), 64'd0);
        check("rst_id", 64'(out_id), 64'd0);
        rst = 1'b0;
        repeat (3) begin
            tick();
            check("idle_valid", 64'(out_valid), 64'd0);
        end

        // Single change: one-cycle latency, one snapshot.
        pv[2] = 32'hDEADBEEF;
        tick();
        snap("single", 2'd2, 32'hDEADBEEF);
        tick();
        check("single_done", 64'(out_valid), 64'd0);

        // Reset again so the pointer favours probe 0.
        pv[2] = '0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;

        // Three simultaneous changes, back-to-back in round-robin order.
        pv[0] = 32'h11;
        pv[1] = 32'h22;
        pv[3] = 32'h33;
        tick();
        snap("multi0", 2'd0, 32'h11);
        tick();
        snap("multi1", 2'd1, 32'h22);
        tick();
        snap("multi3", 2'd3, 32'h33);
        tick();
        check("multi_done", 64'(out_valid), 64'd0);

        // Stall: output holds, changes coalesce to the final value.
        out_ready = 1'b0;
        pv[1] = 32'd1;
        tick();
        snap("stall_first", 2'd1, 32'd1);
        pv[1] = 32'd2;
        tick();
        snap("stall_hold_a", 2'd1, 32'd1);
        pv[1] = 32'd3;
        tick();
        snap("stall_hold_b", 2'd1, 32'd1);
        tick();
        snap("stall_hold_c", 2'd1, 32'd1);
        tick();
        snap("stall_hold_d", 2'd1, 32'd1);
        out_ready = 1'b1;
        tick();
        snap("stall_coalesced", 2'd1, 32'd3);
        tick();
        check("stall_done", 64'(out_valid), 64'd0);

        // Park the pointer on probe 3.
        pv[3] = 32'h44;
        tick();
        snap("p3", 2'd3, 32'h44);
        tick();
        check("p3_done", 64'(out_valid), 64'd0);

        // FORCE with static probes: every probe reported once, in order.
        frc = 1'b1;
        tick();
        frc = 1'b0;
        check("force_edge_valid", 64'(out_valid), 64'd0);
        for (int k = 0; k < c_np; k++) begin
            tick();
            snap($sformatf("force%0d", k), 2'(k), pv[k]);
        end
        tick();
        check("force_done", 64'(out_valid), 64'd0);

        // Reset in the middle of a stalled snapshot.
        out_ready = 1'b0;
        pv[2] = 32'h55;
        tick();
        snap("pre_rst", 2'd2, 32'h55);
        #3 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_out", 64'(out), 64'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;

        // All nonzero probes reported after reset, timestamps counting from 0.
        for (int k = 0; k < c_np; k++) begin
            tick();
            snap($sformatf("post_rst%0d", k), 2'(k), pv[k]);
`ifdef PROBE_TS_EN
            check($sformatf("post_rst_ts%0d", k), 64'(out_ts), 64'(k));
`endif
        end
        tick();
        check("post_rst_done", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/probe_scheduler.md
# probe_scheduler

Shares one registered debug output channel among `NPROBE` probe wires of width `size`. It watches every probe for value changes and arbitrates pending probes round-robin. Each winner is emitted as a snapshot with a valid/ready handshake. The block sits between the design's probe taps and a single trace/readout sink, so many probe points can be observed through one narrow port.

## Interface
Parameters:
- `NPROBE`, default 4: number of probe inputs, 2..16.
- `size`, default 32: width of each probe in bits.

Ports:
- `CLK` input, 1 bit: sole clock.
- `RST` input, 1 bit: reset, asynchronous and active-high.
- `IN` input, `NPROBE*size` bits: probe values; probe i occupies bits `[i*size +: size]`.
- `FORCE` input, 1 bit: one-cycle pulse that marks every probe pending, even if its value is unchanged.
- `OUT` output, `size` bits: snapshot value.
- `OUT_ID` output, `IDW` bits: index of the probe that produced the snapshot. `IDW = max(1, clog2(NPROBE))`.
- `OUT_VALID` output, 1 bit: snapshot is available.
- `OUT_READY` input, 1 bit: sink accepts the snapshot.
- `OUT_TS` output, 32 bits: cycle timestamp of the capture. Present only when `PROBE_TS_EN` is defined.

## Operation
- Per-probe state:
  - `last[i]`: the last value sent for probe i.
  - `fpend[i]`: force-pending flag.
- `req[i] = (IN_i != last[i]) | fpend[i]`, evaluated combinationally every cycle.
- Two-state FSM:
  - IDLE: if any `req` is set, grant probe g and go to SEND. Otherwise stay in IDLE.
  - SEND: `OUT_VALID` = 1. On `OUT_READY`:
    - if any `req` is set, grant the next probe in the same cycle and stay in SEND (back-to-back transfer);
    - otherwise go to IDLE.
- Arbitration is round-robin:
  - Search starts at `ptr+1` (mod `NPROBE`) and takes the first probe with `req` set.
  - On a grant, `ptr <= g`.
- Grant actions, all at the same edge:
  - `OUT <= IN_g`, `OUT_ID <= g`
  - `last[g] <= IN_g`
  - `fpend[g] <= 0`
- Coalescing: a probe that changes several times while waiting is sent once, with the value present at its grant edge. Intermediate values are lost by design.
- Output stability: while `OUT_VALID && !OUT_READY`, `OUT`, `OUT_ID` and `OUT_TS` hold. Probe changes during the stall only update `req`.
- `FORCE` sets all `fpend` bits. If `FORCE` coincides with a grant of probe g, `fpend[g]` ends at 1, so the probe is sent once more.
- A probe that changes after its own grant edge is requested again. It is not served until the other requesters have had their turn.

## Timing
- Reset (asynchronous, immediate): state = IDLE, `OUT_VALID` = 0, `OUT` = 0, `OUT_ID` = 0, all `last` = 0, all `fpend` = 0, `ptr` = `NPROBE-1` (probe 0 wins first), timestamp = 0.
- Because `last` resets to 0, every nonzero probe is reported after reset.
- Reset mid-transfer drops the in-flight snapshot. No partial handshake completes.
- Latency: a change on `IN` in cycle n is granted at the end of cycle n (when idle), and `OUT_VALID` is high in cycle n+1.
- Throughput: one snapshot per cycle while `OUT_READY` = 1 and requests remain.
- A transfer completes on any edge where `OUT_VALID && OUT_READY`. `OUT_VALID` never drops without acceptance, except on reset.

## Configuration
- `PROBE_TS_EN` defined:
  - a free-running 32-bit cycle counter runs, wrapping at 2^32-1 → 0;
  - `OUT_TS` is loaded with the counter value at the grant edge;
  - the `OUT_TS` port exists.
- `PROBE_TS_EN` undefined: no counter and no `OUT_TS` port. All other behaviour is identical.

## Structure
- Shared package `probe_pkg` holds:
  - the FSM state encoding (IDLE = 0, SEND = 1);
  - the `IDW` computation function;
  - the timestamp width constant (32).
- One sub-module, `probe_rr_arb`: a `NPROBE`-wide round-robin priority picker. Inputs are `req` and `ptr`; outputs are `gnt_any` and `gnt_idx`. It is purely combinational.
- The top level holds the FSM, the `last`/`fpend` registers, the output registers and the optional timestamp.

## Test plan
- Reset release with `IN` all 0, `OUT_READY` = 1 → `OUT_VALID` stays 0.
- Probe 2 set to 0xDEADBEEF at cycle 10, `OUT_READY` = 1 → cycle 11 shows `OUT` = 0xDEADBEEF, `OUT_ID` = 2, `OUT_VALID` = 1 for one cycle.
- Probes 0, 1 and 3 change in the same cycle with `OUT_READY` = 1 → three consecutive snapshots with IDs 0, 1, 3, then `OUT_VALID` = 0.
- `OUT_READY` = 0 for 5 cycles while probe 1 goes 1 → 2 → 3 → `OUT` holds its first value; after the ready, exactly one probe-1 snapshot with value 3 follows.
- `FORCE` pulse with all probes static → `NPROBE` snapshots with IDs 0..`NPROBE-1`, carrying the current values.
- `RST` asserted mid-SEND → `OUT_VALID` = 0 immediately; with `PROBE_TS_EN`, the first post-reset snapshot has `OUT_TS` = its cycle count since reset release.
